// File: rtl/ring_counter_param.sv
// ============================================================================
// Module   : ring_counter_param
// Brief    : WIDTH-bit one-hot ring / Johnson counter with direction, load,
//            illegal-state self-correction and wrap/error status pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ring_counter_param #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count_out,
    output logic             wrap,
    output logic             error
);

    localparam logic [WIDTH-1:0] c_RING_HOME = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_JOHN_HOME = '0;
    localparam logic [WIDTH-1:0] c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_error;

    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_home;
    logic [WIDTH-1:0] w_step;
    logic             w_ring_legal;
    logic             w_john_legal;
    logic             w_legal;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;
    logic             w_next_error;

    // Johnson states are low-aligned runs of ones (x & (x+1) == 0) or their
    // complements; checking both forms covers all 2*WIDTH legal patterns.
    always_comb begin
        w_inv        = ~r_count;
        w_ring_legal = (r_count != '0) && ((r_count & (r_count - c_ONE)) == '0);
        w_john_legal = ((r_count & (r_count + c_ONE)) == '0) ||
                       ((w_inv & (w_inv + c_ONE)) == '0);
        w_legal      = mode ? w_john_legal : w_ring_legal;
        w_home       = mode ? c_JOHN_HOME : c_RING_HOME;
    end

    always_comb begin
        w_step = r_count;
        case ({mode, dir})
            2'b00:   w_step = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
            2'b01:   w_step = {r_count[0], r_count[WIDTH-1:1]};
            2'b10:   w_step = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
            default: w_step = {~r_count[0], r_count[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        w_next_error = 1'b0;
        if (load) begin
            w_next_count = load_value;
        end else if (enable) begin
            if (w_legal) begin
                w_next_count = w_step;
                w_next_wrap  = (w_step == w_home);
            end else begin
                w_next_count = w_home;
                w_next_error = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= c_RING_HOME;
            r_wrap  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
            r_error <= w_next_error;
        end
    end

    assign count_out = r_count;
    assign wrap      = r_wrap;
    assign error     = r_error;

endmodule

`default_nettype wire

// File: tb/tb_ring_counter_param.sv
// ============================================================================
// Module   : tb_ring_counter_param
// Brief    : Directed self-checking bench for ring_counter_param (WIDTH = 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ring_counter_param;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       mode;
    logic       dir;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] count_out;
    logic       wrap;
    logic       error;

    int total;
    int bad;

    ring_counter_param #(.WIDTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .count_out  (count_out),
        .wrap       (wrap),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] exp_c,
                         input logic exp_w, input logic exp_e);
        total++;
        assert (count_out === exp_c) else begin
            bad++;
            $error("FAIL %s count observed=%b expected=%b", tag, count_out, exp_c);
        end
        total++;
        assert (wrap === exp_w) else begin
            bad++;
            $error("FAIL %s wrap observed=%b expected=%b", tag, wrap, exp_w);
        end
        total++;
        assert (error === exp_e) else begin
            bad++;
            $error("FAIL %s error observed=%b expected=%b", tag, error, exp_e);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked on the next one.
    task automatic step(input string tag, input logic [3:0] exp_c,
                        input logic exp_w, input logic exp_e);
        @(posedge clock);
        @(negedge clock);
        check(tag, exp_c, exp_w, exp_e);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        enable     = 1'b1;
        mode       = 1'b0;
        dir        = 1'b0;
        load       = 1'b0;
        load_value = 4'b0000;

        #20;
        check("reset", 4'b0001, 1'b0, 1'b0);
        #30;
        reset_n = 1'b1;

        // Ring left, period 4
        step("ring_l1", 4'b0010, 1'b0, 1'b0);
        step("ring_l2", 4'b0100, 1'b0, 1'b0);
        step("ring_l3", 4'b1000, 1'b0, 1'b0);
        step("ring_l4", 4'b0001, 1'b1, 1'b0);

        // Johnson left, period 8
        mode = 1'b1;
        step("john_l1", 4'b0011, 1'b0, 1'b0);
        step("john_l2", 4'b0111, 1'b0, 1'b0);
        step("john_l3", 4'b1111, 1'b0, 1'b0);
        step("john_l4", 4'b1110, 1'b0, 1'b0);
        step("john_l5", 4'b1100, 1'b0, 1'b0);
        step("john_l6", 4'b1000, 1'b0, 1'b0);
        step("john_l7", 4'b0000, 1'b1, 1'b0);
        step("john_l8", 4'b0001, 1'b0, 1'b0);

        // Direction reversal in ring mode
        mode = 1'b0;
        step("rev_a", 4'b0010, 1'b0, 1'b0);
        step("rev_b", 4'b0100, 1'b0, 1'b0);
        dir = 1'b1;
        step("rev_c", 4'b0010, 1'b0, 1'b0);
        step("rev_d", 4'b0001, 1'b1, 1'b0);

        // Johnson right from 0001
        mode = 1'b1;
        step("john_r1", 4'b0000, 1'b1, 1'b0);
        step("john_r2", 4'b1000, 1'b0, 1'b0);

        // Load overrides enable; illegal value caught on next enabled edge
        dir        = 1'b0;
        mode       = 1'b0;
        load       = 1'b1;
        load_value = 4'b0110;
        step("load_r", 4'b0110, 1'b0, 1'b0);
        load = 1'b0;
        step("fix_r", 4'b0001, 1'b0, 1'b1);
        mode = 1'b1;
        load = 1'b1;
        step("load_j", 4'b0110, 1'b0, 1'b0);
        load = 1'b0;
        step("fix_j", 4'b0000, 1'b0, 1'b1);

        // Legal in Johnson, illegal in ring after a mode switch
        load       = 1'b1;
        load_value = 4'b1110;
        step("load_j2", 4'b1110, 1'b0, 1'b0);
        load = 1'b0;
        mode = 1'b0;
        step("mode_sw", 4'b0001, 1'b0, 1'b1);

        // Hold with enable low
        load       = 1'b1;
        load_value = 4'b0100;
        step("load_h", 4'b0100, 1'b0, 1'b0);
        load   = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("hold", 4'b0100, 1'b0, 1'b0);
        end

        // Asynchronous reset between edges
        enable = 1'b1;
        step("pre_rst", 4'b1000, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst", 4'b0001, 1'b0, 1'b0);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst", 4'b0010, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ring_counter_param.md
Name: ring_counter_param

Overview:
- Parametrised successor to the fixed 4-bit ring counter.
- Generates a WIDTH-bit rotating pattern in one of two modes: one-hot ring, period WIDTH; or Johnson/twisted-ring, period 2*WIDTH.
- Adds run-time direction, enable, parallel load, illegal-state self-correction, and wrap/error status pulses.
- Used as a sequencer/phase generator; drives one-hot or thermometer-style select lines.

Parameters:
WIDTH  4  counter width in bits; legal range >= 2

Ports:
Clock       input   1      rising-edge clock
Reset_n     input   1      asynchronous, active-low reset
Enable      input   1      advance one step this cycle when high
Mode        input   1      0 = ring (one-hot), 1 = Johnson
Dir         input   1      0 = shift left (toward MSB), 1 = shift right (toward LSB)
Load        input   1      synchronous parallel load; overrides Enable
Load_value  input   WIDTH  value written on Load
Count_out   output  WIDTH  counter state (registered)
Wrap        output  1      one-cycle pulse: an advance produced the mode's home state
Error       output  1      one-cycle pulse: an illegal state was corrected

Behaviour:
- Reset (Reset_n = 0, asynchronous): Count_out = 0...01 (bit0 set), Wrap = 0, Error = 0. This value is legal in both modes. Release is synchronous to the next Clock edge.
- Home state: ring = 0...01; Johnson = 0...00.
- Legal states, ring mode: exactly one bit set.
- Legal states, Johnson mode: x = 2^k - 1 for k in 0..WIDTH, or x = ~(2^k - 1) for k in 1..WIDTH-1. That gives 2*WIDTH states.
- Priority per rising edge: Load > Enable > hold.
- Load = 1:
  - Count_out <= Load_value verbatim, with no legality check.
  - Wrap <= 0, Error <= 0.
- Enable = 1, Load = 0, state legal for the current Mode: advance one step.
  - Ring, left: {C[W-2:0], C[W-1]}.
  - Ring, right: {C[0], C[W-1:1]}.
  - Johnson, left: {C[W-2:0], ~C[W-1]}.
  - Johnson, right: {~C[0], C[W-1:1]}.
  - Wrap <= 1 if the next value equals the home state, else 0. Error <= 0.
- Enable = 1, Load = 0, state illegal for the current Mode:
  - Count_out <= home state of the current Mode.
  - Error <= 1, Wrap <= 0.
  - No advance in that cycle.
- Enable = 0, Load = 0: Count_out holds; Wrap <= 0, Error <= 0.
- Wrap and Error are registered, one cycle wide, and mutually exclusive. Latency: status is visible in the same cycle as the new Count_out.
- Mode or Dir may change on any cycle and take effect on the next edge. A state legal in the old mode but illegal in the new one is corrected on the next enabled edge (Error pulse).
- Dir reversal mid-sequence: the next step goes in the new direction from the current state. No skip, no extra wait.
- Load of an illegal value is flagged only on the next enabled edge, not at load time.
- Reset asserted mid-operation: immediate return to reset values regardless of Clock, Load or Enable.
- No combinational path from inputs to outputs.

Test Plan (WIDTH = 4):
1. Reset low 50 ns, then release; Mode = 0, Dir = 0, Enable = 1 -> Count_out 0001, 0010, 0100, 1000, 0001. Wrap = 1 only with the second 0001; Error stays 0.
2. Mode = 1, Dir = 0, Enable = 1 from 0001 -> 0011, 0111, 1111, 1110, 1100, 1000, 0000 (Wrap = 1), 0001. Period 8 confirmed.
3. Dir toggles from 0 to 1 at Count_out = 0100 (ring) -> next 0010, then 0001 with Wrap = 1. Then Mode = 1, Dir = 1 from 0001 -> 0000 with Wrap = 1, then 1000.
4. Load = 1, Load_value = 0110, Enable = 1 in the same cycle -> Count_out = 0110, no pulses. Next edge (Mode = 0, Enable = 1) -> Count_out = 0001 with Error = 1. Repeat in Mode = 1 -> Count_out = 0000 with Error = 1.
5. Enable = 0 for 5 cycles at 0100 -> Count_out holds 0100; Wrap = 0 and Error = 0 throughout.
6. Reset_n pulsed low mid-cycle (between edges) while Count_out = 1000 -> Count_out = 0001 immediately, Wrap = 0 and Error = 0. Counting resumes from 0001 on the first edge after release.
